// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data-memory responder for a pipelined CPU MEM stage.
// A request seen in IDLE is captured, the pipeline is stalled for LATENCY cycles,
// and the access completes on the edge that enters DONE.
module dm_responder #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int unsigned IDXW     = $clog2(DEPTH);
   localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            op_wr_q, op_wr_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     data_q, data_d;
   logic            err_q, err_d;
   logic [31:0]     mem_q [DEPTH];

   logic            req;
   logic            commit;
   logic [IDXW-1:0] addr_idx;
   logic            unused_addr;

   assign req         = MemRead_i | MemWrite_i;
   assign addr_idx    = addr_i[IDXW+1:2];
   // Upper address bits are dropped on purpose: out-of-range addresses wrap.
   assign unused_addr = ^addr_i[31:IDXW+2];

   assign data_o = data_q;
   assign err_o  = err_q;

   // Next-state, capture and stall decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      stall_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               stall_o = 1'b1;
               // Write wins when both strobes are high.
               op_wr_d = MemWrite_i;
               idx_d   = addr_idx;
               wdata_d = data_i;
               if ((MemRead_i && MemWrite_i) || (addr_i[1:0] != 2'b00)) begin
                  err_d = 1'b1;
               end
               if (LATENCY > 1) begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = DONE;
                  cnt_d   = '0;
               end
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst_i) begin
         stall_o = 1'b0;
      end
   end

   // The access uses the _d copies so that with LATENCY=1 the capture edge
   // (IDLE->DONE) can commit directly from the live inputs.
   assign commit = (state_d == DONE) && (state_q != DONE) && !rst_i;

   // Load data path: only the DONE-entry edge of a read updates data_o.
   always_comb begin
      data_d = data_q;
      if (commit && !op_wr_d) begin
         data_d = mem_q[idx_d];
      end
   end

   // Control and capture registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Storage array; not reset, so contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (commit && op_wr_d) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=2 instance for the main scenarios,
// LATENCY=1 instance for held back-to-back reads.
module tb_dm_responder;

   logic        clk;
   logic        rst, mr, mw;
   logic [31:0] addr, wdata, q;
   logic        st, er;
   logic        rst1, mr1, mw1;
   logic [31:0] addr1, wd1, q1;
   logic        st1, er1;

   int n_vec = 0;
   int n_err = 0;

   dm_responder #(.DEPTH(32), .LATENCY(2)) dut (
      .clk_i(clk), .rst_i(rst), .MemRead_i(mr), .MemWrite_i(mw),
      .addr_i(addr), .data_i(wdata), .data_o(q), .stall_o(st), .err_o(er)
   );

   dm_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .MemRead_i(mr1), .MemWrite_i(mw1),
      .addr_i(addr1), .data_i(wd1), .data_o(q1), .stall_o(st1), .err_o(er1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the LATENCY=2 DUT in IDLE.
   // Scrambles addr/data during BUSY; returns data_o seen in the DONE cycle
   // and leaves the bench just after the edge that starts the following IDLE cycle.
   task automatic acc(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] qd);
      int n;
      mr = rd; mw = wr; addr = a; wdata = d;
      n = 0;
      @(negedge clk);
      while (st && n < 20) begin
         n++;
         if (n == 2) begin
            addr  = a ^ 32'h4;
            wdata = ~d;
         end
         @(negedge clk);
      end
      chk("stall_cycles", 32'(n), 32'd2);
      qd = q;
      @(posedge clk); #1;
      mr = 1'b0; mw = 1'b0;
      @(negedge clk);
      chk("idle_stall", {31'd0, st}, 32'd0);
      chk("idle_hold", q, qd);
      @(posedge clk); #1;
   endtask

   logic [31:0] r;

   initial begin
      rst = 1'b1; mr = 1'b1; mw = 1'b0; addr = '0; wdata = '0;
      rst1 = 1'b1; mr1 = 1'b0; mw1 = 1'b0; addr1 = '0; wd1 = '0;

      // Reset state; stall must stay low under reset even with a request.
      @(negedge clk);
      chk("rst_stall", {31'd0, st}, 32'd0);
      @(posedge clk); #1;
      mr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_data", q, 32'd0);
      chk("rst_err", {31'd0, er}, 32'd0);
      chk("rst_idle_stall", {31'd0, st}, 32'd0);
      @(posedge clk); #1;

      // Basic write then read.
      acc(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, r);
      acc(1'b1, 1'b0, 32'h8, 32'h0, r);
      chk("rd_0x8", r, 32'hDEADBEEF);
      chk("err_clean", {31'd0, er}, 32'd0);

      // Wrap: 0x80 lands on index 0.
      acc(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, r);
      acc(1'b1, 1'b0, 32'h0, 32'h0, r);
      chk("rd_wrap", r, 32'hA5A5A5A5);
      chk("err_wrap", {31'd0, er}, 32'd0);

      // Reset during BUSY aborts the write.
      acc(1'b0, 1'b1, 32'h10, 32'h11111111, r);
      mw = 1'b1; addr = 32'h10; wdata = 32'h22222222;
      @(negedge clk);
      chk("abort_idle_stall", {31'd0, st}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_stall", {31'd0, st}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mw = 1'b0;
      @(negedge clk);
      chk("abort_after_stall", {31'd0, st}, 32'd0);
      chk("abort_data", q, 32'd0);
      @(posedge clk); #1;
      acc(1'b1, 1'b0, 32'h10, 32'h0, r);
      chk("rd_abort", r, 32'h11111111);

      // Both strobes: write wins, sticky error.
      acc(1'b1, 1'b1, 32'h4, 32'h12345678, r);
      chk("both_err", {31'd0, er}, 32'd1);
      acc(1'b1, 1'b0, 32'h4, 32'h0, r);
      chk("rd_both", r, 32'h12345678);
      chk("err_sticky", {31'd0, er}, 32'd1);

      // Reset clears error but keeps memory; then misaligned read.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", {31'd0, er}, 32'd0);
      @(posedge clk); #1;
      acc(1'b1, 1'b0, 32'h6, 32'h0, r);
      chk("rd_misalign", r, 32'h12345678);
      chk("err_misalign", {31'd0, er}, 32'd1);

      // LATENCY=1: write, then a read held across two back-to-back accesses.
      @(posedge clk); #1;
      rst1 = 1'b0;
      mw1 = 1'b1; addr1 = 32'hC; wd1 = 32'hCAFEF00D;
      @(negedge clk);
      chk("l1_wr_stall_a", {31'd0, st1}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l1_wr_stall_b", {31'd0, st1}, 32'd0);
      @(posedge clk); #1;
      mw1 = 1'b0; mr1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("l1_rd_stall", {31'd0, st1}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 1) chk("l1_rd_data", q1, 32'hCAFEF00D);
         @(posedge clk); #1;
      end
      mr1 = 1'b0;
      @(negedge clk);
      chk("l1_idle_stall", {31'd0, st1}, 32'd0);
      chk("l1_err", {31'd0, er1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
